tl_core_initiator: RTL and testbench

- Per-core TileLink-style initiator: the requester end of the A/D path that the request arbiter, request FIFO, MPU and response FIFO serve.
- Accepts one command at a time from the core and drives that core's tl_a_channel slot into the arbiter until acked.
- Waits for the matching tl_d_channel response on its c_resp slot and returns data, error code or timeout to the core.
- One transaction outstanding per core; late responses are detected and discarded.

---
 rtl/tl_core_initiator.sv | 177 +++++++++++++++++
 tb/tb_tl_core_initiator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_core_initiator.sv
// Per-core TileLink-style A/D initiator: one outstanding request, timeout, stale-response discard.
// Optional statistics counters are enabled by defining TL_INIT_STATS_EN.
module tl_core_initiator #(
    parameter logic [3:0] CORE_ID = 4'd0,
    parameter int         TIMEOUT = 1024,
    parameter int         CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opcode,
    input  logic [2:0]  cmd_param,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic [75:0] req,
    input  logic        ack,
    input  logic [72:0] c_resp,
    output logic        d_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_done,
    output logic [15:0] stat_tmo
);
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  source;
        logic        valid;
        logic        ready;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  source;
        logic        valid;
        logic        ready;
    } tl_d_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    tl_a_t            req_q;
    tl_d_t            d;
    logic [CNT_W-1:0] cnt_q;
    logic             stale_q;
    logic             rsp_valid_q, rsp_timeout_q;
    logic [31:0]      rsp_data_q;
    logic [2:0]       rsp_err_q;

    logic             match, tmo_hit, a_xfer, done_ev, tmo_ev;
    logic [CNT_W-1:0] cnt_inc;
    logic             unused_d;

    assign d        = c_resp;
    assign unused_d = ^{d.address, d.ready};
    assign match    = d.valid && (d.source == CORE_ID);
    // >= so a timeout deferred by a discarded stale match still fires next cycle
    assign tmo_hit  = (cnt_q >= TMO_LAST);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign a_xfer   = (state_q == REQ) && req_q.valid && ack;
    assign done_ev  = (state_q == WAIT) && match && !stale_q;
    assign tmo_ev   = ((state_q == REQ) && !a_xfer && tmo_hit) ||
                      ((state_q == WAIT) && !match && tmo_hit);

    assign cmd_ready   = (state_q == IDLE);
    assign d_ready     = (state_q == IDLE) || (state_q == REQ) ||
                         (state_q == WAIT) || (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign req         = req_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_q         <= '0;
            req_q.source  <= CORE_ID;
            cnt_q         <= '0;
            stale_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= '0;
        end else begin
            if (match && stale_q && state_q != WAIT)
                stale_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    req_q.opcode  <= cmd_opcode;
                    req_q.param   <= cmd_param;
                    req_q.address <= cmd_addr;
                    req_q.data    <= cmd_wdata;
                    req_q.valid   <= 1'b1;
                    req_q.ready   <= 1'b1;
                    cnt_q         <= '0;
                    state_q       <= REQ;
                end
                REQ: begin
                    cnt_q <= cnt_inc;
                    if (a_xfer || tmo_ev) begin
                        req_q.valid <= 1'b0;
                        req_q.ready <= 1'b0;
                    end
                    if (a_xfer) begin
                        state_q <= WAIT;
                    end else if (tmo_ev) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_err_q     <= 3'b111;
                        state_q       <= RESP;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_inc;
                    if (match && stale_q) begin
                        stale_q <= 1'b0;
                    end else if (done_ev) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        rsp_data_q    <= d.data;
                        rsp_err_q     <= d.opcode;
                        state_q       <= RESP;
                    end else if (tmo_ev) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_err_q     <= 3'b111;
                        stale_q       <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef TL_INIT_STATS_EN
    logic [15:0] iss_q, done_q, tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q  <= '0;
            done_q <= '0;
            tmo_q  <= '0;
        end else begin
            if (a_xfer && !(&iss_q))   iss_q  <= iss_q + 16'd1;
            if (done_ev && !(&done_q)) done_q <= done_q + 16'd1;
            if (tmo_ev && !(&tmo_q))   tmo_q  <= tmo_q + 16'd1;
        end
    end

    assign stat_issued = iss_q;
    assign stat_done   = done_q;
    assign stat_tmo    = tmo_q;
`else
    assign stat_issued = '0;
    assign stat_done   = '0;
    assign stat_tmo    = '0;
`endif
endmodule

// File: tb/tb_tl_core_initiator.sv
// Directed bench for tl_core_initiator: main instance TIMEOUT=16, second instance TIMEOUT=8 for the no-ack case.
module tb_tl_core_initiator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_valid8 = 1'b0;
    logic [2:0]  cmd_opcode = '0, cmd_param = '0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        ack = 1'b0, ack8 = 1'b0;
    logic [72:0] c_resp = '0;
    logic        rsp_ready = 1'b0;

    logic        cmd_ready, d_ready, rsp_valid, rsp_timeout, busy;
    logic [75:0] req;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_err;
    logic [15:0] stat_issued, stat_done, stat_tmo;

    logic        cmd_ready8, d_ready8, rsp_valid8, rsp_timeout8, busy8;
    logic [75:0] req8;
    logic [31:0] rsp_data8;
    logic [2:0]  rsp_err8;
    logic [15:0] si8, sd8, st8;

    int passes = 0, checks = 0;
    int ex_iss = 0, ex_done = 0, ex_tmo = 0;

    always #5 clk = ~clk;

    tl_core_initiator #(.CORE_ID(4'd1), .TIMEOUT(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_param(cmd_param), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .req(req), .ack(ack), .c_resp(c_resp), .d_ready(d_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .stat_issued(stat_issued), .stat_done(stat_done), .stat_tmo(stat_tmo));

    tl_core_initiator #(.CORE_ID(4'd1), .TIMEOUT(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
        .cmd_opcode(cmd_opcode), .cmd_param(cmd_param), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .req(req8), .ack(ack8), .c_resp(c_resp), .d_ready(d_ready8),
        .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready), .rsp_data(rsp_data8), .rsp_err(rsp_err8),
        .rsp_timeout(rsp_timeout8), .busy(busy8),
        .stat_issued(si8), .stat_done(sd8), .stat_tmo(st8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // launch a command; ack is raised after 'dly' extra cycles with req.valid up
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w, input int dly);
        cmd_opcode = op; cmd_param = 3'd2; cmd_addr = a; cmd_wdata = w;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("req_valid_up", {31'd0, req[1]}, 32'd1);
        chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        repeat (dly) tick();
        chk("req_valid_pre_ack", {31'd0, req[1]}, 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        ex_iss++;
        chk("req_valid_drop", {31'd0, req[1]}, 32'd0);
    endtask

    task automatic respond(input logic [3:0] src, input logic [2:0] opc, input logic [31:0] dat);
        c_resp = {opc, 32'h0, dat, src, 1'b1, 1'b1};
        tick();
        c_resp = '0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_clr", {31'd0, rsp_valid}, 32'd0);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic chk_stats(input string tag);
        logic [15:0] e_i, e_d, e_t;
`ifdef TL_INIT_STATS_EN
        e_i = 16'(ex_iss); e_d = 16'(ex_done); e_t = 16'(ex_tmo);
`else
        e_i = '0; e_d = '0; e_t = '0;
`endif
        chk({tag, "_issued"}, {16'd0, stat_issued}, {16'd0, e_i});
        chk({tag, "_done"},   {16'd0, stat_done},   {16'd0, e_d});
        chk({tag, "_tmo"},    {16'd0, stat_tmo},    {16'd0, e_t});
    endtask

    initial begin
        #12;
        chk("rst_req", req[31:0], 32'h4);
        chk("rst_req_hi", req[75:44], 32'h0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd1);
        chk("rst_rsp", {rsp_valid, rsp_timeout, busy, rsp_err, rsp_data[25:0]}, 32'd0);
        chk_stats("rst_stats");
        @(negedge clk) rst_n = 1'b1;
        tick();

        // reserve, ack one cycle after valid
        cmd_opcode = 3'b101; cmd_param = 3'd2; cmd_addr = 32'h0000_0106; cmd_wdata = 32'hFFFF_FFFF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("res_valid_c1", {31'd0, req[1]}, 32'd1);
        chk("res_source", {28'd0, req[5:2]}, 32'd1);
        chk("res_opcode", {29'd0, req[75:73]}, 32'd5);
        chk("res_addr", req[69:38], 32'h0000_0106);
        chk("res_data", req[37:6], 32'hFFFF_FFFF);
        chk("res_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("res_valid_c2", {31'd0, req[1]}, 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        ex_iss++;
        chk("res_valid_off", {31'd0, req[1]}, 32'd0);
        respond(4'd1, 3'd0, 32'h40);
        ex_done++;
        chk("res_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("res_rsp_data", rsp_data, 32'h40);
        chk("res_rsp_err", {29'd0, rsp_err}, 32'd0);
        chk("res_rsp_tmo", {31'd0, rsp_timeout}, 32'd0);
        consume();

        // write then read
        issue(3'b010, 32'h0, 32'h0000_FFFF, 0);
        chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        respond(4'd1, 3'd0, 32'h0);
        ex_done++;
        chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wr_cmd_ready_resp", {31'd0, cmd_ready}, 32'd0);
        consume();
        issue(3'b000, 32'h0, 32'h0, 0);
        respond(4'd1, 3'd0, 32'h0000_FFFF);
        ex_done++;
        chk("rd_rsp_data", rsp_data, 32'h0000_FFFF);

        // a command presented with rsp_ready is not taken in that same cycle
        cmd_opcode = 3'b000; cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        chk("no_same_cycle_cmd", {31'd0, busy}, 32'd0);

        // foreign source ignored
        issue(3'b000, 32'h10, 32'h0, 0);
        respond(4'd2, 3'd0, 32'hBAD);
        chk("foreign_ignored", {31'd0, rsp_valid}, 32'd0);
        chk("foreign_busy", {31'd0, busy}, 32'd1);
        respond(4'd1, 3'd3, 32'h55);
        ex_done++;
        chk("foreign_next_data", rsp_data, 32'h55);
        chk("foreign_next_err", {29'd0, rsp_err}, 32'd3);
        consume();

        // no ack on TIMEOUT=8 instance
        cmd_valid8 = 1'b1;
        tick();
        cmd_valid8 = 1'b0;
        repeat (7) tick();
        chk("noack_valid_c8", {31'd0, req8[1]}, 32'd1);
        tick();
        chk("noack_valid_drop", {31'd0, req8[1]}, 32'd0);
        chk("noack_tmo", {31'd0, rsp_timeout8}, 32'd1);
        chk("noack_err", {29'd0, rsp_err8}, 32'd7);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        cmd_valid8 = 1'b1; tick(); cmd_valid8 = 1'b0;
        ack8 = 1'b1; tick(); ack8 = 1'b0;
        respond(4'd1, 3'd0, 32'h99);
        chk("noack_not_stale", rsp_data8, 32'h99);
        chk("noack_rsp_valid", {31'd0, rsp_valid8}, 32'd1);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // timeout in WAIT: result lands 16 cycles after REQ entry
        issue(3'b000, 32'h20, 32'h0, 0);
        repeat (14) tick();
        chk("tmo_not_yet", {31'd0, rsp_valid}, 32'd0);
        tick();
        ex_tmo++;
        chk("tmo_valid", {31'd0, rsp_valid}, 32'd1);
        chk("tmo_flag", {31'd0, rsp_timeout}, 32'd1);
        chk("tmo_err", {29'd0, rsp_err}, 32'd7);
        consume();
        issue(3'b000, 32'h24, 32'h0, 0);
        respond(4'd1, 3'd0, 32'h1234);
        chk("stale_discarded", {31'd0, rsp_valid}, 32'd0);
        respond(4'd1, 3'd0, 32'h77);
        ex_done++;
        chk("after_stale_valid", {31'd0, rsp_valid}, 32'd1);
        chk("after_stale_data", rsp_data, 32'h77);
        chk("after_stale_tmo", {31'd0, rsp_timeout}, 32'd0);
        consume();

        // async reset while waiting
        issue(3'b000, 32'h30, 32'h0, 0);
        chk_stats("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_valid", {31'd0, req[1]}, 32'd0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        ex_iss = 0; ex_done = 0; ex_tmo = 0;
        chk_stats("arst_stats");
        @(negedge clk) rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
